// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and default widths for the register-file write-back arbiter.
// The read-forwarding feature is enabled by defining REGFILE_WB_BYPASS_EN.
package regfile_wb_arbiter_pkg;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational grants plus a priority pointer
// that moves to the other requester after every grant.
module rr_arbiter2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic clock,
  input  logic ctrl_reset,
  input  logic req0,
  input  logic req1,
  output logic grant0,
  output logic grant1
);

  pri_e state_r;
  pri_e next_s;

  // Pointer register.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state_r <= PRI0;
    end else begin
      state_r <= next_s;
    end
  end

  // Grant decode and pointer update; nothing is granted while in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    next_s = state_r;
    if (ctrl_reset) begin
      next_s = PRI0;
    end else begin
      case (state_r)
        PRI0: begin
          grant0 = req0;
          grant1 = req1 & ~req0;
        end
        PRI1: begin
          grant1 = req1;
          grant0 = req0 & ~req1;
        end
        default: begin
          grant0 = 1'b0;
          grant1 = 1'b0;
        end
      endcase
      if (grant0) begin
        next_s = PRI1;
      end else if (grant1) begin
        next_s = PRI0;
      end else begin
        next_s = state_r;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two write-back requesters onto one register-file write port.
// Define REGFILE_WB_BYPASS_EN to forward the pending write onto the read ports.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  wb0_valid,
  output logic                  wb0_ready,
  input  logic [ADDR_WIDTH-1:0] wb0_reg,
  input  logic [DATA_WIDTH-1:0] wb0_data,
  input  logic                  wb1_valid,
  output logic                  wb1_ready,
  input  logic [ADDR_WIDTH-1:0] wb1_reg,
  input  logic [DATA_WIDTH-1:0] wb1_data,
  output logic                  ctrl_writeEnable,
  output logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  output logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  input  logic [DATA_WIDTH-1:0] rf_readA,
  input  logic [DATA_WIDTH-1:0] rf_readB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  output logic [CNT_WIDTH-1:0]  conflict_count
);

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = {ADDR_WIDTH{1'b0}};

  logic                  we_r;
  logic [ADDR_WIDTH-1:0] wreg_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [CNT_WIDTH-1:0]  cnt_r;
  logic                  xfer_s;
  logic [ADDR_WIDTH-1:0] sel_reg_s;
  logic [DATA_WIDTH-1:0] sel_data_s;

  rr_arbiter2 u_arb (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .req0       (wb0_valid),
    .req1       (wb1_valid),
    .grant0     (wb0_ready),
    .grant1     (wb1_ready)
  );

  // Select the winning requester's payload.
  always_comb begin
    xfer_s     = 1'b0;
    sel_reg_s  = wreg_r;
    sel_data_s = wdata_r;
    if (wb0_ready) begin
      xfer_s     = 1'b1;
      sel_reg_s  = wb0_reg;
      sel_data_s = wb0_data;
    end else if (wb1_ready) begin
      xfer_s     = 1'b1;
      sel_reg_s  = wb1_reg;
      sel_data_s = wb1_data;
    end else begin
      xfer_s = 1'b0;
    end
  end

  // Output stage; register 0 is accepted but never written.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      we_r    <= 1'b0;
      wreg_r  <= REG_ZERO;
      wdata_r <= {DATA_WIDTH{1'b0}};
    end else if (xfer_s) begin
      we_r    <= (sel_reg_s != REG_ZERO);
      wreg_r  <= sel_reg_s;
      wdata_r <= sel_data_s;
    end else begin
      we_r <= 1'b0;
    end
  end

  // Saturating count of cycles where both requesters competed.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (wb0_valid && wb1_valid && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign ctrl_writeEnable = we_r;
  assign ctrl_writeReg    = wreg_r;
  assign data_writeReg    = wdata_r;
  assign conflict_count   = cnt_r;

`ifdef REGFILE_WB_BYPASS_EN
  assign data_readRegA = (we_r && (ctrl_readRegA == wreg_r) && (wreg_r != REG_ZERO)) ? wdata_r : rf_readA;
  assign data_readRegB = (we_r && (ctrl_readRegB == wreg_r) && (wreg_r != REG_ZERO)) ? wdata_r : rf_readB;
`else
  logic unused_read_addr_s;
  assign unused_read_addr_s = ^{ctrl_readRegA, ctrl_readRegB};
  assign data_readRegA      = rf_readA;
  assign data_readRegB      = rf_readB;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised bench for regfile_wb_arbiter against a behavioural model, plus directed cases.
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic        wb0_valid = 1'b0, wb1_valid = 1'b0;
  logic [4:0]  wb0_reg = 5'd0, wb1_reg = 5'd0;
  logic [31:0] wb0_data = 32'd0, wb1_data = 32'd0;
  logic [4:0]  ctrl_readRegA = 5'd0, ctrl_readRegB = 5'd0;
  logic [31:0] rf_readA = 32'd0, rf_readB = 32'd0;

  logic        wb0_ready, wb1_ready, ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg, data_readRegA, data_readRegB;
  logic [15:0] conflict_count;

  logic        s_wb0_ready, s_wb1_ready, s_we;
  logic [4:0]  s_wreg;
  logic [31:0] s_wdata, s_rda, s_rdb;
  logic [1:0]  s_cnt;

  int checks = 0;
  int failures = 0;
  bit checking = 1'b0;

  always #5 clock = ~clock;

  regfile_wb_arbiter dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_reg(wb0_reg), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_reg(wb1_reg), .wb1_data(wb1_data),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .rf_readA(rf_readA), .rf_readB(rf_readB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .conflict_count(conflict_count)
  );

  regfile_wb_arbiter #(.CNT_WIDTH(2)) dut_small (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .wb0_valid(wb0_valid), .wb0_ready(s_wb0_ready), .wb0_reg(wb0_reg), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(s_wb1_ready), .wb1_reg(wb1_reg), .wb1_data(wb1_data),
    .ctrl_writeEnable(s_we), .ctrl_writeReg(s_wreg), .data_writeReg(s_wdata),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .rf_readA(rf_readA), .rf_readB(rf_readB),
    .data_readRegA(s_rda), .data_readRegB(s_rdb),
    .conflict_count(s_cnt)
  );

  // Behavioural model: favoured requester, last accepted write, conflict tallies.
  int          exp_fav = 0;
  logic        exp_we = 1'b0;
  logic [4:0]  exp_wreg = 5'd0;
  logic [31:0] exp_wdata = 32'd0;
  int          exp_cnt = 0;
  int          exp_cnt2 = 0;

  wire exp_rdy0 = !ctrl_reset && wb0_valid && (!wb1_valid || exp_fav == 0);
  wire exp_rdy1 = !ctrl_reset && wb1_valid && (!wb0_valid || exp_fav == 1);

  always @(posedge clock) begin
    if (ctrl_reset) begin
      exp_fav <= 0; exp_we <= 1'b0; exp_wreg <= 5'd0; exp_wdata <= 32'd0;
      exp_cnt <= 0; exp_cnt2 <= 0;
    end else begin
      if (exp_rdy0) begin
        exp_we <= (wb0_reg != 5'd0); exp_wreg <= wb0_reg; exp_wdata <= wb0_data; exp_fav <= 1;
      end else if (exp_rdy1) begin
        exp_we <= (wb1_reg != 5'd0); exp_wreg <= wb1_reg; exp_wdata <= wb1_data; exp_fav <= 0;
      end else begin
        exp_we <= 1'b0;
      end
      if (wb0_valid && wb1_valid) begin
        exp_cnt  <= (exp_cnt  >= 65535) ? 65535 : exp_cnt + 1;
        exp_cnt2 <= (exp_cnt2 >= 3) ? 3 : exp_cnt2 + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] addr, input logic [31:0] raw);
`ifdef REGFILE_WB_BYPASS_EN
    return (exp_we && addr == exp_wreg && exp_wreg != 5'd0) ? exp_wdata : raw;
`else
    return raw + 32'd0 + {27'd0, addr & 5'd0};
`endif
  endfunction

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clock) begin
    if (checking) begin
      chk("wb0_ready", wb0_ready, exp_rdy0);
      chk("wb1_ready", wb1_ready, exp_rdy1);
      chk("writeEnable", ctrl_writeEnable, exp_we);
      chk("writeReg", ctrl_writeReg, exp_wreg);
      chk("writeData", data_writeReg, exp_wdata);
      chk("conflict_count", conflict_count, exp_cnt);
      chk("conflict_count_w2", s_cnt, exp_cnt2);
      chk("readA", data_readRegA, exp_read(ctrl_readRegA, rf_readA));
      chk("readB", data_readRegB, exp_read(ctrl_readRegB, rf_readB));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    ctrl_reset = 1'b1; wb0_valid = 1'b0; wb1_valid = 1'b0;
    tick();
    ctrl_reset = 1'b0;
  endtask

  initial begin
    tick();
    checking = 1'b1;
    tick();
    // Reset state and readies held low under reset.
    wb0_valid = 1'b1; wb1_valid = 1'b1;
    @(negedge clock);
    chk("rst_ready0", wb0_ready, 1'b0);
    chk("rst_we", ctrl_writeEnable, 1'b0);
    chk("rst_reg", ctrl_writeReg, 5'd0);
    chk("rst_data", data_writeReg, 32'd0);
    chk("rst_cnt", conflict_count, 16'd0);
    do_reset();

    // Single requester write.
    wb0_valid = 1'b1; wb0_reg = 5'd3; wb0_data = 32'hDEADBEEF;
    @(negedge clock); chk("d033_ready", wb0_ready, 1'b1);
    tick(); wb0_valid = 1'b0;
    @(negedge clock);
    chk("d033_we", ctrl_writeEnable, 1'b1);
    chk("d033_reg", ctrl_writeReg, 5'd3);
    chk("d033_data", data_writeReg, 32'hDEADBEEF);
    tick();

    // Four conflicting cycles alternate grants.
    do_reset();
    wb0_valid = 1'b1; wb0_reg = 5'd4; wb0_data = 32'h44;
    wb1_valid = 1'b1; wb1_reg = 5'd5; wb1_data = 32'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("d034_g0", wb0_ready, (i % 2) == 0);
      chk("d034_g1", wb1_ready, (i % 2) == 1);
      if (i > 0) chk("d034_wreg", ctrl_writeReg, ((i - 1) % 2 == 0) ? 5'd4 : 5'd5);
      tick();
    end
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    @(negedge clock);
    chk("d034_cnt", conflict_count, 16'd4);
    chk("d034_last", ctrl_writeReg, 5'd5);
    tick();

    // Register 0 accepted without a write.
    wb1_valid = 1'b1; wb1_reg = 5'd0; wb1_data = 32'h1234;
    @(negedge clock); chk("d035_ready", wb1_ready, 1'b1);
    tick(); wb1_valid = 1'b0;
    @(negedge clock); chk("d035_we", ctrl_writeEnable, 1'b0);
    tick();

    // Read forwarding of the pending write.
    wb0_valid = 1'b1; wb0_reg = 5'd7; wb0_data = 32'hA5A5A5A5;
    tick(); wb0_valid = 1'b0; ctrl_readRegA = 5'd7; rf_readA = 32'd0;
    @(negedge clock);
`ifdef REGFILE_WB_BYPASS_EN
    chk("d036_fwd", data_readRegA, 32'hA5A5A5A5);
`else
    chk("d036_fwd", data_readRegA, 32'd0);
`endif
    tick();

    // Reset discards a pending write and restores the pointer.
    wb0_valid = 1'b1; wb0_reg = 5'd9; wb0_data = 32'h99;
    tick(); wb0_valid = 1'b0; ctrl_reset = 1'b1;
    tick(); ctrl_reset = 1'b0;
    @(negedge clock);
    chk("d037_we", ctrl_writeEnable, 1'b0);
    chk("d037_cnt", conflict_count, 16'd0);
    wb0_valid = 1'b1; wb1_valid = 1'b1;
    #1 chk("d037_ptr", wb0_ready, 1'b1);
    tick();

    // Small counter saturates.
    do_reset();
    wb0_valid = 1'b1; wb1_valid = 1'b1;
    repeat (6) tick();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    @(negedge clock);
    chk("d038_sat", s_cnt, 2'd3);
    chk("d038_cnt", conflict_count, 16'd6);
    tick();

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      ctrl_reset = ($urandom_range(0, 59) == 0);
      wb0_valid  = ($urandom_range(0, 9) < 6);
      wb1_valid  = ($urandom_range(0, 9) < 6);
      wb0_reg    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      wb1_reg    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      wb0_data   = $urandom;
      wb1_data   = $urandom;
      ctrl_readRegA = ($urandom_range(0, 1) == 1) ? exp_wreg : 5'($urandom_range(0, 31));
      ctrl_readRegB = ($urandom_range(0, 1) == 1) ? exp_wreg : 5'($urandom_range(0, 31));
      rf_readA   = $urandom;
      rf_readB   = $urandom;
      tick();
    end

    ctrl_reset = 1'b0; wb0_valid = 1'b0; wb1_valid = 1'b0;
    tick();
    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
